// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle CPU sequencer: fetch/decode/execute/memory/write-back control,
// memory-acknowledge timeout watchdog and retired-instruction counter.
module cpu_seq_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        dec_write_en,
  input  logic [1:0]  dec_wb_sel,
  input  logic        dec_write,
  input  logic        dec_illegal,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        pc_en,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_r;
  state_t      next_state_s;
  logic [7:0]  wait_cnt_r;
  logic [7:0]  wait_cnt_next_s;
  logic        err_r;
  logic [15:0] retired_r;
  logic        timeout_s;
  logic        is_store_s;
  logic        is_load_s;

  // A store wins over a load-style write-back select.
  assign is_store_s = dec_write_en;
  assign is_load_s  = (dec_wb_sel == 2'b10) && !dec_write_en;

  // Next-state and strobe decode.
  always_comb begin
    next_state_s = state_r;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    pc_en        = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = FETCH;
        else       next_state_s = IDLE;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load      = 1'b1;
          next_state_s = DECODE;
        end else if (wait_cnt_r == TIMEOUT_C) begin
          timeout_s    = 1'b1;
          next_state_s = HALT;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
        if (dec_illegal) next_state_s = HALT;
        else             next_state_s = EXEC;
      end
      EXEC: begin
        if (is_load_s || is_store_s) begin
          next_state_s = MEM;
        end else if (dec_write) begin
          next_state_s = WB;
        end else begin
          pc_en        = 1'b1;
          next_state_s = FETCH;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_write_en;
        if (dmem_ack) begin
          if (is_store_s) begin
            pc_en        = 1'b1;
            next_state_s = FETCH;
          end else begin
            next_state_s = WB;
          end
        end else if (wait_cnt_r == TIMEOUT_C) begin
          timeout_s    = 1'b1;
          next_state_s = HALT;
        end else begin
          next_state_s = MEM;
        end
      end
      WB: begin
        rf_we        = 1'b1;
        pc_en        = 1'b1;
        next_state_s = FETCH;
      end
      HALT: begin
        next_state_s = HALT;
      end
      default: begin
        next_state_s = HALT;
      end
    endcase
  end

  // Wait counter: restart on entry to a memory-wait state, saturate at TIMEOUT.
  always_comb begin
    wait_cnt_next_s = wait_cnt_r;
    if ((next_state_s != state_r) && ((next_state_s == FETCH) || (next_state_s == MEM))) begin
      wait_cnt_next_s = 8'd0;
    end else if (((state_r == FETCH) && !imem_ack) || ((state_r == MEM) && !dmem_ack)) begin
      if (wait_cnt_r != TIMEOUT_C) wait_cnt_next_s = wait_cnt_r + 8'd1;
      else                         wait_cnt_next_s = wait_cnt_r;
    end else begin
      wait_cnt_next_s = wait_cnt_r;
    end
  end

  // State, wait counter, sticky error and retire counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      wait_cnt_r <= 8'd0;
      err_r      <= 1'b0;
      retired_r  <= 16'd0;
    end else begin
      state_r    <= next_state_s;
      wait_cnt_r <= wait_cnt_next_s;
      err_r      <= err_r | timeout_s;
      retired_r  <= retired_r + {15'd0, pc_en};
    end
  end

  assign busy    = (state_r != IDLE) && (state_r != HALT);
  assign halted  = (state_r == HALT);
  assign err     = err_r;
  assign state   = state_r;
  assign retired = retired_r;

endmodule
